// File: rtl/logic_pipe_pkg.sv
// Shared types and the bitwise operation evaluator for logic_pipe.
package logic_pipe_pkg;

    localparam int unsigned MaxWidth = 64;

    typedef enum logic [2:0] {
        OpAnd    = 3'd0,
        OpOr     = 3'd1,
        OpNand   = 3'd2,
        OpNor    = 3'd3,
        OpXor    = 3'd4,
        OpXnor   = 3'd5,
        OpAndNot = 3'd6,
        OpPassA  = 3'd7
    } logic_op_e;

    // Evaluates op at MaxWidth bits; bits at and above width are forced to zero.
    function automatic logic [MaxWidth-1:0] logic_eval(
        input logic_op_e             op,
        input logic [MaxWidth-1:0]   a,
        input logic [MaxWidth-1:0]   b,
        input int unsigned           width
    );
        logic [MaxWidth-1:0] mask;
        logic [MaxWidth-1:0] r;
        if (width >= MaxWidth) begin
            mask = '1;
        end else begin
            mask = (MaxWidth'(1) << width) - MaxWidth'(1);
        end
        case (op)
            OpAnd:    r = a & b;
            OpOr:     r = a | b;
            OpNand:   r = ~(a & b);
            OpNor:    r = ~(a | b);
            OpXor:    r = a ^ b;
            OpXnor:   r = ~(a ^ b);
            OpAndNot: r = a & ~b;
            default:  r = a;
        endcase
        return r & mask;
    endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// One elastic register slice carrying {valid, data, zero}; loads when empty or draining.
module logic_pipe_stage
    import logic_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 23
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_zero,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;
    logic             open;

    always_comb begin
        open    = !valid_q || out_ready;
        valid_d = valid_q;
        data_d  = data_q;
        zero_d  = zero_q;
        if (open) begin
            valid_d = in_valid;
        end
        // Data only captured on a real load so idle registers keep their value.
        if (open && in_valid) begin
            data_d = in_data;
            zero_d = in_zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            zero_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_zero  = zero_q;

endmodule

// File: rtl/logic_pipe.sv
// Pipelined bitwise logic unit with valid/ready handshakes on both sides.
// Optional transaction counter (txn_count) is enabled by defining LOGIC_PIPE_CNT_EN.
module logic_pipe
    import logic_pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = 23,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
`ifdef LOGIC_PIPE_CNT_EN
    ,
    output logic [CNT_W-1:0] txn_count
`endif
);

    if (WIDTH < 1 || WIDTH > MaxWidth) begin : g_bad_width
        $error("logic_pipe: WIDTH out of range");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("logic_pipe: STAGES out of range");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("logic_pipe: CNT_W must be at least 1");
    end

    logic [MaxWidth-1:0] eval_full;
    logic [WIDTH-1:0]    res;
    logic                res_zero;

    always_comb begin
        eval_full = logic_eval(logic_op_e'(op), MaxWidth'(a), MaxWidth'(b), WIDTH);
        res       = eval_full[WIDTH-1:0];
        res_zero  = (eval_full == '0);
    end

    logic [STAGES-1:0] stg_valid;
    logic [STAGES-1:0] stg_zero;
    logic [WIDTH-1:0]  stg_data [STAGES];
    logic [STAGES-1:0] stg_adv;

    // Stage k may advance if the output takes a beat or any later stage has a hole.
    // Written without chaining stg_adv on itself to keep the ready path loop-free.
    always_comb begin
        for (int k = 0; k < int'(STAGES); k++) begin
            stg_adv[k] = out_ready;
            for (int j = k + 1; j < int'(STAGES); j++) begin
                if (!stg_valid[j]) begin
                    stg_adv[k] = 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
        logic             s_in_valid;
        logic [WIDTH-1:0] s_in_data;
        logic             s_in_zero;

        if (k == 0) begin : g_head
            assign s_in_valid = in_valid;
            assign s_in_data  = res;
            assign s_in_zero  = res_zero;
        end else begin : g_body
            assign s_in_valid = stg_valid[k-1];
            assign s_in_data  = stg_data[k-1];
            assign s_in_zero  = stg_zero[k-1];
        end

        logic_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (s_in_valid),
            .in_data   (s_in_data),
            .in_zero   (s_in_zero),
            .out_ready (stg_adv[k]),
            .out_valid (stg_valid[k]),
            .out_data  (stg_data[k]),
            .out_zero  (stg_zero[k])
        );
    end

    assign in_ready  = !stg_valid[0] || stg_adv[0];
    assign out_valid = stg_valid[STAGES-1];
    assign out_data  = stg_data[STAGES-1];
    assign out_zero  = stg_zero[STAGES-1];

`ifdef LOGIC_PIPE_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign txn_count = cnt_q;
`endif

endmodule

// File: tb/tb_logic_pipe.sv
// Randomized and directed bench for logic_pipe (WIDTH=23, STAGES=2) with a queue scoreboard.
module tb_logic_pipe;

    localparam int unsigned W     = 23;
    localparam int unsigned S     = 2;
    localparam int unsigned CW    = 4;
    localparam logic [63:0] MASK  = 64'h7F_FFFF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    op = 3'd0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic          out_zero;
`ifdef LOGIC_PIPE_CNT_EN
    logic [CW-1:0] txn_count;
`endif

    always #5 clk = ~clk;

    logic_pipe #(
        .WIDTH  (W),
        .STAGES (S),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
`ifdef LOGIC_PIPE_CNT_EN
        ,
        .txn_count (txn_count)
`endif
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned acc_cnt = 0;
    int unsigned hs_cnt = 0;
    logic [63:0] exp_q[$];
    logic        stall_prev = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic        prev_zero = 1'b0;
    logic        last_ov = 1'b0;

    logic [2:0]  bo [4];
    logic [W-1:0] ba [4];
    logic [W-1:0] bb [4];
    int unsigned bi = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Operation table straight from the operation list, truncated to 23 bits.
    function automatic logic [63:0] model(input int unsigned o, input logic [63:0] x,
                                          input logic [63:0] y);
        case (o)
            0:       return x & y;
            1:       return x | y;
            2:       return MASK ^ (x & y);
            3:       return MASK ^ (x | y);
            4:       return x ^ y;
            5:       return MASK ^ (x ^ y);
            6:       return x & (MASK ^ y);
            default: return x;
        endcase
    endfunction

    // Handshakes are decided by the values seen at the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", 64'(out_data), 64'(prev_data));
                check("stall_zero", 64'(out_zero), 64'(prev_zero));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 64'd1, 64'd0);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    check("sb_data", 64'(out_data), e);
                    check("sb_zero", 64'(out_zero), 64'(e == 64'd0));
                end
                hs_cnt++;
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_zero  = out_zero;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(int'(op), 64'(a), 64'(b)));
                acc_cnt++;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_zero", 64'(out_zero), 64'd0);
        exp_q.delete();
        hs_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef LOGIC_PIPE_CNT_EN
        check("rst_txn_count", 64'(txn_count), 64'd0);
`endif
    endtask

    // Presents beat bi (held until accepted) for one cycle.
    task automatic drive_cycle();
        logic took;
        if (bi < 4) begin
            in_valid = 1'b1;
            op = bo[bi];
            a  = ba[bi];
            b  = bb[bi];
        end else begin
            in_valid = 1'b0;
        end
        @(negedge clk);
        took    = in_valid && in_ready;
        last_ov = out_valid;
        @(posedge clk);
        #1;
        if (took) bi++;
    endtask

    task automatic send_one(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic [W-1:0] e, input logic z);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op = o;
        a  = x;
        b  = y;
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check({tag, "_early"}, 64'(out_valid), 64'd0);
        tick();
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"}, 64'(out_data), 64'(e));
        check({tag, "_zero"}, 64'(out_zero), 64'(z));
        tick();
    endtask

    task automatic load_beats();
        for (int i = 0; i < 4; i++) begin
            bo[i] = 3'($urandom_range(0, 7));
            ba[i] = W'($urandom);
            bb[i] = W'($urandom);
        end
        bi = 0;
    endtask

    task automatic random_run(input string tag, input int unsigned beats);
        int unsigned sent;
        int unsigned cyc;
        logic took;
        sent = 0;
        cyc  = 0;
        while (sent < beats && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 9) < 8);
            op        = 3'($urandom_range(0, 7));
            a         = W'($urandom);
            b         = W'($urandom);
            if ($urandom_range(0, 7) == 0) a = '0;
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (took) sent++;
            cyc++;
        end
        check({tag, "_sent"}, 64'(sent), 64'(beats));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            tick();
            cyc++;
        end
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned acc0;
        int unsigned nv;

        // Reset held from time zero
        #3;
        check("init_valid", 64'(out_valid), 64'd0);
        check("init_data", 64'(out_data), 64'd0);
        check("init_zero", 64'(out_zero), 64'd0);
        check("init_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        send_one("nand_ones", 3'd2, 23'h7FFFFF, 23'h7FFFFF, 23'h000000, 1'b1);
        send_one("xor_alt", 3'd4, 23'h2AAAAA, 23'h555555, 23'h7FFFFF, 1'b0);
        send_one("nor_zero", 3'd3, 23'h000000, 23'h000000, 23'h7FFFFF, 1'b0);
        send_one("xnor_eq", 3'd5, 23'h123456, 23'h123456, 23'h7FFFFF, 1'b0);
        send_one("andnot", 3'd6, 23'h7F00FF, 23'h0F0F0F, 23'h7000F0, 1'b0);
        send_one("pass_a", 3'd7, 23'h000000, 23'h7FFFFF, 23'h000000, 1'b1);

        // Backpressure: capacity is exactly STAGES beats
        load_beats();
        out_ready = 1'b0;
        acc0 = acc_cnt;
        for (int c = 0; c < 6; c++) drive_cycle();
        check("bp_accepted", 64'(acc_cnt - acc0), 64'(S));
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_head", 64'(out_data), model(int'(bo[0]), 64'(ba[0]), 64'(bb[0])));
        out_ready = 1'b1;
        nv = 0;
        for (int c = 0; c < 4; c++) begin
            drive_cycle();
            nv += int'(last_ov);
        end
        check("bp_rate", 64'(nv), 64'd4);
        check("bp_total", 64'(acc_cnt - acc0), 64'd4);
        tick();
        check("bp_empty", 64'(exp_q.size()), 64'd0);

        // Reset with beats in flight
        load_beats();
        out_ready = 1'b0;
        drive_cycle();
        drive_cycle();
        check("mid_inflight", 64'(out_valid), 64'd1);
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("mid_no_stale", 64'(out_valid), 64'd0);
        end
        tick();

        random_run("soak", 10000);
`ifdef LOGIC_PIPE_CNT_EN
        check("cnt_soak", 64'(txn_count), 64'(hs_cnt % (1 << CW)));
        do_reset();
        random_run("cnt17", 17);
        check("cnt_hs", 64'(hs_cnt), 64'd17);
        check("cnt_wrap", 64'(txn_count), 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/logic_pipe.md
# logic_pipe

Parametrised, pipelined bitwise logic unit. Successor to the fixed 23-bit NAND cell:
- Width and pipeline depth are configurable.
- An operation is selected per transaction.
- Operands enter and results leave through valid/ready handshakes with full backpressure.
- Sits between operand sources and consumers in the logic-op regression harnesses and datapaths; the bench's random stimulus/checker drives it.

## Interface
Parameters:
- WIDTH, 23: operand/result width in bits, 1..64.
- STAGES, 2: pipeline register stages, 1..4.
- CNT_W, 16: transaction counter width; used only with LOGIC_PIPE_CNT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept the beat.
- op  in  3  operation: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 A&~B, 7 pass A.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  result.
- out_zero  out  1  out_data is all zeros.
- txn_count  out  CNT_W  completed output handshakes; present only with LOGIC_PIPE_CNT_EN.

## Operation
- Input accept: in_valid && in_ready on a rising edge.
- The result f(op,a,b) is computed combinationally and registered into stage 0 together with out_zero.
- Stages 1..STAGES-1 carry {valid, data, zero}. The last stage drives out_valid, out_data and out_zero.
- Elastic pipeline. Stage k loads when it is empty, or when its contents move to k+1 in the same cycle. The last stage empties on out_valid && out_ready.
- in_ready = !stage0_valid || stage0 advancing. It is combinational from out_ready through the chain; there are no bubbles.
- Ordering is strict FIFO; no beat is dropped or duplicated.
- While out_valid && !out_ready, out_data and out_zero stay stable.
- Data registers hold their value when their valid bit is low; only valid bits gate behaviour.
- Results are exactly WIDTH bits: NAND/NOR/XNOR invert only within WIDTH. There is no sign interpretation.

## Timing
- Reset (rst_n low, asynchronous): all valid bits 0, data 0, zero flags 0, txn_count 0.
  - Resulting outputs: out_valid=0, out_data=0, out_zero=0, in_ready=1 as soon as reset is released.
- Reset mid-operation discards all in-flight beats. No partial results appear after release.
- Latency: a beat accepted at edge N shows out_valid=1 after edge N+STAGES-1, i.e. STAGES edges inclusive of accept, with no stalls.
- Throughput: one beat per cycle while out_ready=1.
- Full: all STAGES valid and out_ready=0 gives in_ready=0.
- Same-cycle accept and emit when full is allowed.
- Capacity is exactly STAGES beats.
- Empty pipeline with in_valid=0: out_valid=0.
- out_valid does not depend combinationally on in_valid.

## Configuration
- LOGIC_PIPE_CNT_EN defined:
  - Adds txn_count, which increments on each out_valid && out_ready.
  - Wraps from 2^CNT_W-1 to 0.
  - Reset to 0.
- Not defined: the counter logic and the txn_count port are absent. Datapath behaviour is identical.

## Structure
- Shared package logic_pipe_pkg contains:
  - op enum logic_op_e with values AND..PASS_A.
  - Function logic_eval(op,a,b), parameterised through a max-width argument and masked by WIDTH.
- One sub-module, logic_pipe_stage: a single elastic register slice ({valid,data,zero}, load/advance logic).
  - Instantiated STAGES times in a generate loop.
- Top level holds the op evaluation and the optional counter.

## Test plan
- Directed ops, WIDTH=23, STAGES=2, out_ready=1:
  - NAND a=0x7FFFFF, b=0x7FFFFF -> out_data=0x000000, out_zero=1, two edges after accept.
  - XOR a=0x2AAAAA, b=0x555555 -> 0x7FFFFF, out_zero=0.
- Inversion masking, WIDTH=23: NOR a=0, b=0 -> 0x7FFFFF; no bit 23 set.
- Backpressure, STAGES=2:
  - Drive 4 beats with out_ready=0 -> exactly 2 accepted, in_ready=0, out_data stable.
  - Release out_ready -> all 4 results in order, 1/cycle.
- Reset mid-stream: assert rst_n=0 with 2 beats in flight -> out_valid=0 and out_data=0 immediately; no stale result after release.
- Random soak: 10000 beats, random op/a/b and random out_ready -> scoreboard matches logic_eval, in order, with no loss.
- With LOGIC_PIPE_CNT_EN, CNT_W=4: 17 handshakes -> txn_count=1 (wrapped); stalled cycles do not count.
